// File: rtl/xor2_pipe_reg.sv
// One-entry valid/ready pipeline register. Accepts a word when the stage is
// empty or draining in the same cycle, and holds it stable under backpressure.
module xor2_pipe_reg #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic               valid_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic               vld_p0;
    logic [width_p-1:0] data_p0;
    logic               take_in;

    // Stage can accept when empty or when its current word leaves this cycle.
    always_comb begin
        ready_o = !vld_p0 || ready_i;
        take_in = valid_i && ready_o;
    end

    // Stage register: load on transfer-in, clear on drain-only, else hold.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (take_in) begin
            vld_p0  <= 1'b1;
            data_p0 <= data_i;
        end else if (ready_i) begin
            vld_p0  <= 1'b0;
        end
    end

    assign data_o  = data_p0;
    assign valid_o = vld_p0;

endmodule

// File: rtl/xor2.sv
// Bitwise XOR with two views of the result: a zero-latency combinational
// output and an optional one-entry registered output with valid/ready flow.
module xor2 #(
    parameter int width_p   = 1,
    parameter bit reg_out_p = 1'b1
) (
    input  logic               clk_i,
    input  logic               reset_ni,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    output logic [width_p-1:0] c_o,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [width_p-1:0] c_r_o,
    output logic               valid_o,
    input  logic               ready_i
);

    logic [width_p-1:0] xor_res;

    // Combinational result; independent of clock and reset.
    always_comb begin
        xor_res = a_i ^ b_i;
    end

    assign c_o = xor_res;

    if (reg_out_p) begin : g_reg
        xor2_pipe_reg #(
            .width_p (width_p)
        ) u_pipe_reg (
            .clk_i    (clk_i),
            .reset_ni (reset_ni),
            .valid_i  (valid_i),
            .data_i   (xor_res),
            .ready_o  (ready_o),
            .data_o   (c_r_o),
            .valid_o  (valid_o),
            .ready_i  (ready_i)
        );
    end else begin : g_noreg
        // Registered path absent: outputs sit at their idle/reset values and
        // the request handshake is never back-pressured.
        assign ready_o = 1'b1;
        assign c_r_o   = '0;
        assign valid_o = 1'b0;
    end

    // Combinational output always matches the operands (X propagates equally).
    always_comb begin
        a_comb : assert (c_o === (a_i ^ b_i));
    end

    // A stalled result must not move or disappear.
    a_hold : assert property (@(posedge clk_i) disable iff (!reset_ni)
        (valid_o && !ready_i) |=> (valid_o && $stable(c_r_o)));

    // Valid flag is always a known value once out of reset.
    a_vld_known : assert property (@(posedge clk_i)
        reset_ni |-> !$isunknown(valid_o));

endmodule

// File: tb/tb_xor2.sv
// Directed bench for xor2: truth table on a 1-bit instance, then the
// registered path of an 8-bit instance through load, stall, drain,
// simultaneous in/out and asynchronous reset.
module tb_xor2;

    logic       clk;
    logic       reset_ni;

    logic       a1, b1, c1, valid1_i, ready1_o, c1_r, valid1_o, ready1_i;

    logic [7:0] a8, b8, c8, c8_r;
    logic       valid8_i, ready8_o, valid8_o, ready8_i;

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    xor2 #(.width_p(1), .reg_out_p(1'b1)) u_dut1 (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .a_i      (a1),
        .b_i      (b1),
        .c_o      (c1),
        .valid_i  (valid1_i),
        .ready_o  (ready1_o),
        .c_r_o    (c1_r),
        .valid_o  (valid1_o),
        .ready_i  (ready1_i)
    );

    xor2 #(.width_p(8), .reg_out_p(1'b1)) u_dut8 (
        .clk_i    (clk),
        .reset_ni (reset_ni),
        .a_i      (a8),
        .b_i      (b8),
        .c_o      (c8),
        .valid_i  (valid8_i),
        .ready_o  (ready8_o),
        .c_r_o    (c8_r),
        .valid_o  (valid8_o),
        .ready_i  (ready8_i)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            $display("pass %s", tag);
        end else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ni = 1'b0;
        a1 = 1'b0; b1 = 1'b0; valid1_i = 1'b0; ready1_i = 1'b0;
        a8 = 8'h00; b8 = 8'h00; valid8_i = 1'b0; ready8_i = 1'b0;
        #2;

        // Reset state of the registered path.
        check("rst_valid_o", {63'd0, valid8_o}, 64'd0);
        check("rst_c_r_o",   {56'd0, c8_r},     64'd0);
        check("rst_ready_o", {63'd0, ready8_o}, 64'd1);

        // Truth table on the 1-bit instance, each vector held 10 ns.
        a1 = 1'b0; b1 = 1'b0; #1; check("tt_00", {63'd0, c1}, 64'd0); #9;
        a1 = 1'b1; b1 = 1'b0; #1; check("tt_10", {63'd0, c1}, 64'd1); #9;
        a1 = 1'b0; b1 = 1'b1; #1; check("tt_01", {63'd0, c1}, 64'd1); #9;
        a1 = 1'b1; b1 = 1'b1; #1; check("tt_11", {63'd0, c1}, 64'd0); #9;

        // Leave reset away from the rising edge.
        @(negedge clk);
        reset_ni = 1'b1;

        // 8-bit combinational result then a single load.
        a8 = 8'hA5; b8 = 8'hFF; #1;
        check("comb_a5ff", {56'd0, c8}, 64'h5A);
        valid8_i = 1'b1; ready8_i = 1'b1;
        step();
        check("load_c_r_o",   {56'd0, c8_r},     64'h5A);
        check("load_valid_o", {63'd0, valid8_o}, 64'd1);

        // Backpressure: a new request must not displace the stalled result.
        ready8_i = 1'b0; valid8_i = 1'b1; a8 = 8'h33; b8 = 8'h0F; #1;
        check("bp_ready_o_comb", {63'd0, ready8_o}, 64'd0);
        check("bp_c_o",          {56'd0, c8},       64'h3C);
        step();
        check("bp1_c_r_o",   {56'd0, c8_r},     64'h5A);
        check("bp1_valid_o", {63'd0, valid8_o}, 64'd1);
        check("bp1_ready_o", {63'd0, ready8_o}, 64'd0);
        step();
        check("bp2_c_r_o",   {56'd0, c8_r},     64'h5A);
        check("bp2_valid_o", {63'd0, valid8_o}, 64'd1);

        // Release without a new request: drains, data unchanged.
        valid8_i = 1'b0; ready8_i = 1'b1; #1;
        check("rel_ready_o", {63'd0, ready8_o}, 64'd1);
        step();
        check("drain_valid_o", {63'd0, valid8_o}, 64'd0);
        check("drain_c_r_o",   {56'd0, c8_r},     64'h5A);

        // Load C3, then simultaneous in/out with 0F^01.
        valid8_i = 1'b1; a8 = 8'hC3; b8 = 8'h00;
        step();
        check("load2_c_r_o",   {56'd0, c8_r},     64'hC3);
        check("load2_valid_o", {63'd0, valid8_o}, 64'd1);
        a8 = 8'h0F; b8 = 8'h01; #1;
        check("sim_ready_o", {63'd0, ready8_o}, 64'd1);
        step();
        check("sim_c_r_o",   {56'd0, c8_r},     64'h0E);
        check("sim_valid_o", {63'd0, valid8_o}, 64'd1);

        // Hold under stall with no request.
        valid8_i = 1'b0; ready8_i = 1'b0;
        step();
        check("hold_c_r_o",   {56'd0, c8_r},     64'h0E);
        check("hold_valid_o", {63'd0, valid8_o}, 64'd1);

        // Asynchronous reset between edges while holding a result.
        #3;
        reset_ni = 1'b0; a8 = 8'h12; b8 = 8'h34; #1;
        check("arst_valid_o", {63'd0, valid8_o}, 64'd0);
        check("arst_c_r_o",   {56'd0, c8_r},     64'd0);
        check("arst_c_o",     {56'd0, c8},       64'h26);

        // No transfer completes while reset is held.
        valid8_i = 1'b1; ready8_i = 1'b1;
        step();
        check("inrst_valid_o", {63'd0, valid8_o}, 64'd0);
        check("inrst_c_r_o",   {56'd0, c8_r},     64'd0);

        // First rising edge after deassertion accepts a request.
        @(negedge clk);
        reset_ni = 1'b1; a8 = 8'hFF; b8 = 8'h0F;
        step();
        check("post_c_r_o",   {56'd0, c8_r},     64'hF0);
        check("post_valid_o", {63'd0, valid8_o}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
